// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch -- instruction fetch front end feeding the IF/ID pipeline register.
//
// Owns the fetch PC, issues word requests over a req/gnt/rvalid memory port,
// buffers in-order responses in a small queue and presents the queue head
// ({inst_addr_o, inst_o}) combinationally to IF/ID.
//
// Ports:
//   clk_i, rst_i         clock (rising edge), async active-high reset
//   imem_req_o/addr_o    fetch request and word-aligned address
//   imem_gnt_i           request accepted this cycle
//   imem_rvalid_i/rdata_i in-order response word
//   inst_addr_o/inst_o   head PC and instruction (NOP when queue empty)
//   inst_valid_o         queue non-empty
//   stall_i              hold head, no dequeue
//   flush_i/flush_addr_i redirect fetch; stale in-flight responses dropped
//
// Optional build macro IF_FETCH_PERF_EN adds saturating counters:
//   perf_bubble_o  cycles with no valid output while not stalled/flushed
//   perf_discard_o responses dropped as stale
// ---------------------------------------------------------------------------
module if_fetch #(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    output logic                  imem_req_o,
    output logic [ADDR_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    output logic [ADDR_WIDTH-1:0] inst_addr_o,
    output logic [DATA_WIDTH-1:0] inst_o,
    output logic                  inst_valid_o,
    input  logic                  stall_i,
    input  logic                  flush_i,
    input  logic [ADDR_WIDTH-1:0] flush_addr_i
`ifdef IF_FETCH_PERF_EN
    ,
    output logic [31:0]           perf_bubble_o,
    output logic [31:0]           perf_discard_o
`endif
);

    localparam int unsigned PW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW-1:0] FD_C = CW'(FIFO_DEPTH);
    localparam logic [CW:0]   FD_S = (CW + 1)'(FIFO_DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [ADDR_WIDTH-1:0] r_fetch_pc;
    logic [ADDR_WIDTH-1:0] r_head_pc;
    logic [DATA_WIDTH-1:0] r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_rd_ptr;
    logic [PW-1:0]         r_wr_ptr;
    logic [CW-1:0]         r_count;
    logic [CW-1:0]         r_pending;
    logic [CW-1:0]         r_discard;

    logic                  w_req;
    logic                  w_gnt;
    logic                  w_rsp_keep;
    logic                  w_rsp_drop;
    logic                  w_deq;
    logic [CW:0]           w_credit_used;
    logic [ADDR_WIDTH-1:0] w_flush_pc;

    // Credit covers both queued words and words still owed by memory, so a
    // granted request always has a slot waiting for it.
    assign w_credit_used = {1'b0, r_pending} + {1'b0, r_count};
    assign w_req         = !rst_i && !flush_i && (w_credit_used < FD_S);
    assign w_gnt         = w_req && imem_gnt_i;
    // A response landing in a flush cycle is stale as well.
    assign w_rsp_keep    = imem_rvalid_i && !flush_i && (r_discard == '0);
    assign w_rsp_drop    = imem_rvalid_i && !w_rsp_keep;
    assign w_deq         = inst_valid_o && !stall_i && !flush_i;
    assign w_flush_pc    = flush_addr_i & ~ADDR_WIDTH'(3);

    assign imem_req_o   = w_req;
    assign imem_addr_o  = r_fetch_pc;
    assign inst_valid_o = (r_count != '0);
    assign inst_addr_o  = r_head_pc;
    assign inst_o       = inst_valid_o ? r_mem[r_rd_ptr] : NOP;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_fetch_pc <= RESET_PC;
            r_head_pc  <= RESET_PC;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            r_pending  <= '0;
            r_discard  <= '0;
        end else begin
            r_pending <= r_pending + CW'(w_gnt) - CW'(imem_rvalid_i);
            if (flush_i) begin
                r_fetch_pc <= w_flush_pc;
                r_head_pc  <= w_flush_pc;
                r_rd_ptr   <= '0;
                r_wr_ptr   <= '0;
                r_count    <= '0;
                // Everything still owed is stale; a response arriving now is
                // already being dropped.
                r_discard  <= r_pending - CW'(imem_rvalid_i);
            end else begin
                if (w_gnt) begin
                    r_fetch_pc <= r_fetch_pc + ADDR_WIDTH'(4);
                end
                if (w_deq) begin
                    r_head_pc <= r_head_pc + ADDR_WIDTH'(4);
                    r_rd_ptr  <= r_rd_ptr + PW'(1);
                end
                if (w_rsp_keep) begin
                    r_wr_ptr <= r_wr_ptr + PW'(1);
                end
                if (w_rsp_drop) begin
                    r_discard <= r_discard - CW'(1);
                end
                r_count <= r_count + CW'(w_rsp_keep) - CW'(w_deq);
            end
        end
    end

    // Data storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk_i) begin
        if (w_rsp_keep) begin
            r_mem[r_wr_ptr] <= imem_rdata_i;
        end
    end

    a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
        !(w_rsp_keep && !w_deq && (r_count == FD_C)));

    a_no_orphan_rsp: assert property (@(posedge clk_i) disable iff (rst_i)
        !(imem_rvalid_i && (r_pending == '0)));

`ifdef IF_FETCH_PERF_EN
    logic [31:0] r_perf_bubble;
    logic [31:0] r_perf_discard;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_perf_bubble  <= '0;
            r_perf_discard <= '0;
        end else begin
            if (!inst_valid_o && !stall_i && !flush_i && (r_perf_bubble != '1)) begin
                r_perf_bubble <= r_perf_bubble + 32'd1;
            end
            if (w_rsp_drop && (r_perf_discard != '1)) begin
                r_perf_discard <= r_perf_discard + 32'd1;
            end
        end
    end

    assign perf_bubble_o  = r_perf_bubble;
    assign perf_discard_o = r_perf_discard;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch -- randomized self-checking bench for if_fetch.
//
// The reference model tracks the memory's outstanding requests (each tagged
// stale once a redirect passes it) and the list of instruction addresses the
// front end should be presenting; expected outputs follow from these lists.
// ---------------------------------------------------------------------------
module tb_if_fetch;

    localparam int unsigned AW  = 32;
    localparam int unsigned DW  = 32;
    localparam int unsigned FD  = 2;
    localparam logic [31:0] RPC = 32'h0000_0100;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          imem_req_o;
    logic [AW-1:0] imem_addr_o;
    logic          imem_gnt_i;
    logic          imem_rvalid_i;
    logic [DW-1:0] imem_rdata_i;
    logic [AW-1:0] inst_addr_o;
    logic [DW-1:0] inst_o;
    logic          inst_valid_o;
    logic          stall_i;
    logic          flush_i;
    logic [AW-1:0] flush_addr_i;

    if_fetch #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .RESET_PC   (RPC),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_gnt_i    (imem_gnt_i),
        .imem_rvalid_i (imem_rvalid_i),
        .imem_rdata_i  (imem_rdata_i),
        .inst_addr_o   (inst_addr_o),
        .inst_o        (inst_o),
        .inst_valid_o  (inst_valid_o),
        .stall_i       (stall_i),
        .flush_i       (flush_i),
        .flush_addr_i  (flush_addr_i)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] addr;
        bit          stale;
        int          ready;
    } mreq_t;

    mreq_t       mq[$];     // requests granted by memory, not yet answered
    logic [31:0] exp_q[$];  // instruction addresses the DUT should be holding
    logic [31:0] m_fpc;     // next address the DUT should request
    int          cyc = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    int          n_consumed = 0;
    bit          rel_pending = 1'b0;
    bit          obs_valid;
    logic [31:0] obs_addr;

    bit          k_stall = 1'b0;
    bit          k_flush = 1'b0;
    logic [31:0] k_faddr = '0;
    int          k_gnt_pct = 100;
    int          k_lat_min = 1;
    int          k_lat_max = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_clear();
        mq.delete();
        exp_q.delete();
        m_fpc = RPC;
    endtask

    task automatic quiet_inputs();
        stall_i       = 1'b0;
        flush_i       = 1'b0;
        flush_addr_i  = '0;
        imem_gnt_i    = 1'b0;
        imem_rvalid_i = 1'b0;
        imem_rdata_i  = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   {31'b0, imem_req_o},   32'd0);
        check({tag, "_valid"}, {31'b0, inst_valid_o}, 32'd0);
        check({tag, "_inst"},  inst_o,                NOP);
        check({tag, "_iaddr"}, inst_addr_o,           RPC);
    endtask

    // One clock cycle: drive at negedge, check combinational outputs against
    // the model, then advance the model by what the coming edge will do.
    task automatic cycle();
        bit          resp;
        bit          exp_req;
        mreq_t       r;
        @(negedge clk_i);
        if (rel_pending) begin
            rst_i       = 1'b0;
            rel_pending = 1'b0;
        end
        stall_i      = k_stall;
        flush_i      = k_flush;
        flush_addr_i = k_faddr;
        imem_gnt_i   = ($urandom_range(99) < k_gnt_pct);
        resp         = (mq.size() != 0) && (mq[0].ready <= cyc);
        imem_rvalid_i = resp;
        imem_rdata_i  = resp ? mem_word(mq[0].addr) : $urandom;
        #1;
        exp_req = !k_flush && ((mq.size() + exp_q.size()) < FD);
        check("req", {31'b0, imem_req_o}, {31'b0, exp_req});
        if (imem_req_o) check("fetch_addr", imem_addr_o, m_fpc);
        check("valid", {31'b0, inst_valid_o}, {31'b0, exp_q.size() != 0});
        if (exp_q.size() != 0) begin
            check("inst_addr", inst_addr_o, exp_q[0]);
            check("inst", inst_o, mem_word(exp_q[0]));
        end else begin
            check("inst_nop", inst_o, NOP);
        end
        obs_valid = inst_valid_o;
        obs_addr  = inst_addr_o;

        if (exp_q.size() != 0 && !k_stall && !k_flush) begin
            void'(exp_q.pop_front());
            n_consumed++;
        end
        if (resp) begin
            r = mq.pop_front();
            if (!r.stale && !k_flush) exp_q.push_back(r.addr);
        end
        if (k_flush) begin
            exp_q.delete();
            foreach (mq[i]) mq[i].stale = 1'b1;
            m_fpc = k_faddr & ~32'd3;
        end else if (imem_req_o && imem_gnt_i) begin
            mq.push_back('{addr: imem_addr_o, stale: 1'b0,
                           ready: cyc + $urandom_range(k_lat_max, k_lat_min)});
            m_fpc = m_fpc + 32'd4;
            check("outstanding_cap", {31'b0, mq.size() <= FD}, 32'd1);
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int          first_valid;
        logic [31:0] first_addr;
        bit          got_first;
        bit          did_rst;
        int          budget;

        quiet_inputs();
        rst_i = 1'b1;
        #1;
        check_reset_outputs("rst");
        repeat (3) @(posedge clk_i);
        model_clear();
        rel_pending = 1'b1;

        // Streaming from reset: first valid two cycles after the first grant.
        first_valid = -1;
        for (int i = 0; i < 12; i++) begin
            cycle();
            if (first_valid < 0 && obs_valid) begin
                first_valid = i;
                check("first_addr", obs_addr, RPC);
            end
        end
        check("first_valid_cyc", first_valid, 32'd2);

        // Stall: credit runs out, head held; release resumes in order.
        k_stall = 1'b1;
        run(6);
        k_stall = 1'b0;
        run(6);

        // Two requests outstanding to 0x200, then redirect to 0x3003.
        k_flush = 1'b1; k_faddr = 32'h0000_0200;
        run(1);
        k_flush = 1'b0; k_lat_min = 5; k_lat_max = 5;
        run(3);
        k_flush = 1'b1; k_faddr = 32'h0000_3003;
        run(1);
        k_flush = 1'b0; k_lat_min = 1; k_lat_max = 1;
        got_first = 1'b0;
        first_addr = '0;
        for (int i = 0; i < 16; i++) begin
            cycle();
            if (!got_first && obs_valid) begin
                got_first  = 1'b1;
                first_addr = obs_addr;
            end
        end
        check("flush_first_addr", first_addr, 32'h0000_3000);

        // Full queue, flush and stall together.
        k_stall = 1'b1;
        run(4);
        k_flush = 1'b1; k_faddr = 32'h0000_4000;
        run(1);
        k_flush = 1'b0;
        run(1);
        check("flush_stall_empty", {31'b0, obs_valid}, 32'd0);
        k_stall = 1'b0;
        run(8);

        // PC wrap at the top of the address space.
        k_flush = 1'b1; k_faddr = 32'hFFFF_FFF8;
        run(1);
        k_flush = 1'b0;
        run(10);

        // Random traffic with one asynchronous reset part-way through.
        k_gnt_pct = 70; k_lat_min = 1; k_lat_max = 5;
        n_consumed = 0;
        did_rst = 1'b0;
        budget = 20000;
        while (n_consumed < 1000 && budget > 0) begin
            k_stall = ($urandom_range(99) < 20);
            k_flush = ($urandom_range(99) < 2);
            k_faddr = $urandom;
            cycle();
            budget--;
            if (!did_rst && n_consumed >= 500) begin
                did_rst = 1'b1;
                @(posedge clk_i);
                #2;
                rst_i = 1'b1;
                #1;
                check_reset_outputs("async_rst");
                quiet_inputs();
                repeat (2) @(posedge clk_i);
                model_clear();
                rel_pending = 1'b1;
            end
        end
        check("random_budget", {31'b0, budget > 0}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
